uart_weight_loader: RTL and testbench
=====================================

// Module: uart_weight_loader
// PURPOSE
//  Frame parser between uart_rx_a and LSTM_TOP: takes received UART bytes, checks a framed
//  weight-download packet (header, length, payload, checksum) and forwards payload bytes as the
//  tdata/t_valid stream LSTM_TOP consumes. Sends a one-byte ACK/NAK back through uart_tx_a.
// PARAMETERS
//  DATA_WIDTH   8          UART byte width; all data ports use this width
//  HDR0         8'h79      first header byte
//  HDR1         8'h91      second header byte
//  MAX_LEN      18432      max payload bytes (64*64*4 + 32*64 weight image)
//  ACK_OK       8'h1E      reply byte, good frame
//  ACK_ERR      8'hE1      reply byte, bad frame
//  TIMEOUT_CYC  500000     inter-byte timeout in clocks (10 ms @ 50 MHz); used only with the macro
// PORTS
//  i_clk_sys     in   1   system clock (50 MHz)
//  i_rst_n       in   1   asynchronous active-low reset
//  i_rx_data     in   8   byte from uart_rx_a o_uart_data
//  i_rx_done     in   1   1-cycle strobe; i_rx_data is valid in that cycle
//  o_tdata       out  8   payload byte to LSTM_TOP tdata
//  o_tvalid      out  1   1-cycle strobe per payload byte (LSTM_TOP t_valid)
//  o_byte_cnt    out  16  payload bytes forwarded in the current frame
//  o_frame_done  out  1   1-cycle pulse, frame accepted (checksum OK)
//  o_frame_err   out  1   1-cycle pulse, frame rejected
//  o_ack_data    out  8   reply byte to uart_tx_a i_data_tx
//  o_ack_valid   out  1   1-cycle strobe to uart_tx_a i_data_valid
//  i_tx_ready    in   1   uart_tx_a idle/ready
//  o_busy        out  1   high in every state except S_IDLE
// BEHAVIOUR
//  Reset: state S_IDLE; every output 0; length, count and checksum registers 0.
//  Frame: HDR0 HDR1 LEN_H LEN_L payload[LEN] CSUM; CSUM = sum of payload bytes mod 256.
//  FSM (advances only on i_rx_done, except S_ACK):
//   S_IDLE : byte==HDR0 -> S_HDR1; any other byte is ignored.
//   S_HDR1 : HDR1 -> S_LENH; HDR0 -> stay in S_HDR1; any other byte -> S_IDLE. No error here.
//   S_LENH : latch len[15:8] -> S_LENL.
//   S_LENL : latch len[7:0]. If len==0 or len>MAX_LEN: o_frame_err pulse, ACK_ERR -> S_ACK.
//            Otherwise clear cnt and sum -> S_PAY.
//   S_PAY  : o_tdata<=byte and o_tvalid=1 for one cycle, exactly 1 clk after i_rx_done.
//            cnt+=1; sum+=byte (8-bit wrap). When cnt reaches len -> S_CSUM.
//   S_CSUM : byte==sum: o_frame_done pulse, ACK_OK. Otherwise: o_frame_err pulse, ACK_ERR.
//            Both go to S_ACK.
//   S_ACK  : wait for i_tx_ready=1, then one-cycle o_ack_valid with o_ack_data held.
//            Then -> S_IDLE. i_rx_done in S_ACK is ignored and the byte is dropped.
//  Payload goes out before the checksum is checked. On o_frame_err, LSTM_TOP discards the
//   partially loaded weights.
//  o_byte_cnt holds its value after the frame ends; it clears at the next S_LENL->S_PAY.
//  o_tdata holds the last payload byte between strobes. Throughput is bounded by UART, no backpressure.
//  Async reset mid-frame: return to S_IDLE immediately; no ACK, no pulses.
// CONFIGURATION
//  UART_LOADER_TIMEOUT_EN defined:
//   - Gap counter clears on every i_rx_done and counts in every state except S_IDLE and S_ACK.
//   - At TIMEOUT_CYC: o_frame_err pulse, ACK_ERR -> S_ACK.
//  Undefined: no counter logic; the FSM waits indefinitely for the next byte.
// TESTING
//  1 good frame 79 91 00 03 | 0A 0B 0C | 21 -> 3 o_tvalid with 0A,0B,0C; o_byte_cnt=3;
//    o_frame_done x1; ack 1E.
//  2 bad csum 79 91 00 02 | FF 02 | 00 -> FF,02 forwarded (sum wraps to 01);
//    o_frame_err x1; ack E1.
//  3 length 79 91 48 01 (18433>MAX_LEN) -> no o_tvalid; o_frame_err x1; ack E1; then frame 1 passes.
//  4 resync 79 79 91 00 01 | 55 | 55 -> accepted; 55 forwarded once; ack 1E. Also 79 12 -> S_IDLE, no ack.
//  5 reset: assert i_rst_n=0 after 2 payload bytes of a 4-byte frame -> all outputs 0, o_busy=0,
//    no ack; next frame 1 passes.
//  6 (TIMEOUT_EN) 79 91 00 04 0A then silence > TIMEOUT_CYC -> o_frame_err x1; ack E1; S_IDLE.
//  All cases: hold i_tx_ready=0 for 100 clks in S_ACK -> o_ack_valid only after ready rises.

Source files
------------

// File: rtl/uart_weight_loader.sv
// Frame parser between the UART receiver and LSTM_TOP: validates a weight-download frame,
// streams payload bytes and answers with ACK/NAK. Optional macro: UART_LOADER_TIMEOUT_EN.
module uart_weight_loader #(
    parameter int unsigned               DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]     HDR0        = 8'h79,
    parameter logic [DATA_WIDTH-1:0]     HDR1        = 8'h91,
    parameter int unsigned               MAX_LEN     = 18432,
    parameter logic [DATA_WIDTH-1:0]     ACK_OK      = 8'h1E,
    parameter logic [DATA_WIDTH-1:0]     ACK_ERR     = 8'hE1,
    parameter int unsigned               TIMEOUT_CYC = 500000
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    output logic [15:0]           o_byte_cnt,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic [DATA_WIDTH-1:0] o_ack_data,
    output logic                  o_ack_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR1 = 3'd1,
        S_LENH = 3'd2,
        S_LENL = 3'd3,
        S_PAY  = 3'd4,
        S_CSUM = 3'd5,
        S_ACK  = 3'd6
    } state_t;

    state_t                  state_r;
    logic [15:0]             len_r;
    logic [15:0]             cnt_r;
    logic [DATA_WIDTH-1:0]   sum_r;
    logic [DATA_WIDTH-1:0]   tdata_r;
    logic                    tvalid_r;
    logic                    frame_done_r;
    logic                    frame_err_r;
    logic [DATA_WIDTH-1:0]   ack_data_r;
    logic                    ack_valid_r;
    logic                    busy_r;

    logic [15:0]             len_s;
    logic                    len_ok_s;
    logic [15:0]             cnt_nxt_s;
    logic                    timeout_s;

    // Checksum is the plain modulo-2^DATA_WIDTH sum of the payload bytes.
    function automatic logic [DATA_WIDTH-1:0] csum_add(
        input logic [DATA_WIDTH-1:0] sum,
        input logic [DATA_WIDTH-1:0] data
    );
        return sum + data;
    endfunction

    assign len_s     = {len_r[15:8], i_rx_data[7:0]};
    assign len_ok_s  = (len_s != 16'd0) && (len_s <= 16'(MAX_LEN));
    assign cnt_nxt_s = cnt_r + 16'd1;

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

    logic [GAP_W-1:0] gap_r;
    logic             gap_run_s;

    assign gap_run_s = (state_r != S_IDLE) && (state_r != S_ACK);
    assign timeout_s = gap_run_s && !i_rx_done && (gap_r == GAP_W'(TIMEOUT_CYC - 1));

    // Inter-byte gap counter, restarted by every received byte.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_r <= '0;
        end else if (i_rx_done || !gap_run_s || timeout_s) begin
            gap_r <= '0;
        end else begin
            gap_r <= gap_r + GAP_W'(1);
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT_CYC == 32'd0);
    assign timeout_s        = 1'b0;
`endif

    // Frame FSM; all outputs are registered and strobes default low every cycle.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= S_IDLE;
            len_r        <= 16'd0;
            cnt_r        <= 16'd0;
            sum_r        <= '0;
            tdata_r      <= '0;
            tvalid_r     <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            ack_data_r   <= '0;
            ack_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            tvalid_r     <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            ack_valid_r  <= 1'b0;
            if (timeout_s) begin
                frame_err_r <= 1'b1;
                ack_data_r  <= ACK_ERR;
                state_r     <= S_ACK;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (i_rx_done && (i_rx_data == HDR0)) begin
                            state_r <= S_HDR1;
                            busy_r  <= 1'b1;
                        end
                    end
                    S_HDR1: begin
                        if (i_rx_done) begin
                            if (i_rx_data == HDR1) begin
                                state_r <= S_LENH;
                            end else if (i_rx_data == HDR0) begin
                                state_r <= S_HDR1;
                            end else begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    S_LENH: begin
                        if (i_rx_done) begin
                            len_r[15:8] <= i_rx_data[7:0];
                            state_r     <= S_LENL;
                        end
                    end
                    S_LENL: begin
                        if (i_rx_done) begin
                            len_r <= len_s;
                            if (len_ok_s) begin
                                cnt_r   <= 16'd0;
                                sum_r   <= '0;
                                state_r <= S_PAY;
                            end else begin
                                frame_err_r <= 1'b1;
                                ack_data_r  <= ACK_ERR;
                                state_r     <= S_ACK;
                            end
                        end
                    end
                    S_PAY: begin
                        if (i_rx_done) begin
                            tdata_r  <= i_rx_data;
                            tvalid_r <= 1'b1;
                            cnt_r    <= cnt_nxt_s;
                            sum_r    <= csum_add(sum_r, i_rx_data);
                            if (cnt_nxt_s == len_r) begin
                                state_r <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (i_rx_done) begin
                            if (i_rx_data == sum_r) begin
                                frame_done_r <= 1'b1;
                                ack_data_r   <= ACK_OK;
                            end else begin
                                frame_err_r <= 1'b1;
                                ack_data_r  <= ACK_ERR;
                            end
                            state_r <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        // Bytes arriving while the reply is pending are dropped.
                        if (i_tx_ready) begin
                            ack_valid_r <= 1'b1;
                            state_r     <= S_IDLE;
                            busy_r      <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_tdata      = tdata_r;
    assign o_tvalid     = tvalid_r;
    assign o_byte_cnt   = cnt_r;
    assign o_frame_done = frame_done_r;
    assign o_frame_err  = frame_err_r;
    assign o_ack_data   = ack_data_r;
    assign o_ack_valid  = ack_valid_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_uart_weight_loader.sv
// Scoreboard bench for uart_weight_loader: expected payload/ACK bytes are queued as frames
// are sent and checked when the DUT strobes them.
`timescale 1ns/1ps
module tb_uart_weight_loader;

    localparam int unsigned TO_CYC = 200;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tdata;
    logic        tvalid;
    logic [15:0] byte_cnt;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  ack_data;
    logic        ack_valid;
    logic        busy;

    int total = 0;
    int bad = 0;
    int tv_cnt = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_tdata_q[$];
    logic [7:0] exp_ack_q[$];

    always #5 clk_sys = ~clk_sys;

    uart_weight_loader #(.TIMEOUT_CYC(TO_CYC)) dut (
        .i_clk_sys   (clk_sys),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .o_tdata     (tdata),
        .o_tvalid    (tvalid),
        .o_byte_cnt  (byte_cnt),
        .o_frame_done(frame_done),
        .o_frame_err (frame_err),
        .o_ack_data  (ack_data),
        .o_ack_valid (ack_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy)
    );

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clk_sys) begin
        logic [7:0] e;
        if (tvalid) begin
            tv_cnt++;
            total++;
            if (exp_tdata_q.size() == 0) begin
                bad++;
                $display("FAIL tdata_unexpected got=%h expected=none", tdata);
            end else begin
                e = exp_tdata_q.pop_front();
                if (tdata !== e) begin
                    bad++;
                    $display("FAIL tdata got=%h expected=%h", tdata, e);
                end
            end
        end
        if (ack_valid) begin
            ack_cnt++;
            total++;
            if (exp_ack_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected got=%h expected=none", ack_data);
            end else begin
                e = exp_ack_q.pop_front();
                if (ack_data !== e) begin
                    bad++;
                    $display("FAIL ack_data got=%h expected=%h", ack_data, e);
                end
            end
        end
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk_sys);
        rx_done = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    // Holds tx_ready low for 100 clocks, then releases it and expects exactly one ACK.
    task automatic finish_ack(input string name);
        int a0;
        a0 = ack_cnt;
        tx_ready = 1'b0;
        repeat (100) @(negedge clk_sys);
        total++;
        if (ack_cnt !== a0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_ack_hold got acks=%0d busy=%b expected acks=%0d busy=1", name, ack_cnt - a0, busy, 0);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && ack_cnt == a0; i++) @(negedge clk_sys);
        repeat (2) @(negedge clk_sys);
        tx_ready = 1'b0;
        total++;
        if (ack_cnt !== a0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_release got acks=%0d busy=%b expected acks=1 busy=0", name, ack_cnt - a0, busy);
        end
    endtask

    task automatic check_counts(input string name, input int d0, input int e0, input int t0,
                                input int exp_d, input int exp_e, input int exp_t);
        total++;
        if (done_cnt - d0 !== exp_d || err_cnt - e0 !== exp_e || tv_cnt - t0 !== exp_t ||
            exp_tdata_q.size() != 0 || exp_ack_q.size() != 0) begin
            bad++;
            $display("FAIL %s_counts got done=%0d err=%0d tvalid=%0d pend=%0d/%0d expected done=%0d err=%0d tvalid=%0d pend=0/0",
                     name, done_cnt - d0, err_cnt - e0, tv_cnt - t0, exp_tdata_q.size(), exp_ack_q.size(),
                     exp_d, exp_e, exp_t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        total++;
        if ({tdata, tvalid, byte_cnt, frame_done, frame_err, ack_data, ack_valid, busy} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs got tdata=%h tv=%b cnt=%0d done=%b err=%b ack=%h av=%b busy=%b expected all 0",
                     tdata, tvalid, byte_cnt, frame_done, frame_err, ack_data, ack_valid, busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_good_frame();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt;
        exp_tdata_q.push_back(8'h0A); exp_tdata_q.push_back(8'h0B); exp_tdata_q.push_back(8'h0C);
        exp_ack_q.push_back(8'h1E);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h21);
        finish_ack("good");
        check_counts("good", d0, e0, t0, 1, 0, 3);
        total++;
        if (byte_cnt !== 16'd3 || tdata !== 8'h0C) begin
            bad++;
            $display("FAIL good_cnt got cnt=%0d tdata=%h expected cnt=3 tdata=0c", byte_cnt, tdata);
        end
    endtask

    task automatic test_bad_csum();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt;
        exp_tdata_q.push_back(8'hFF); exp_tdata_q.push_back(8'h02);
        exp_ack_q.push_back(8'hE1);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00);
        finish_ack("csum");
        check_counts("csum", d0, e0, t0, 0, 1, 2);
        total++;
        if (byte_cnt !== 16'd2) begin
            bad++;
            $display("FAIL csum_cnt got=%0d expected=2", byte_cnt);
        end
    endtask

    task automatic test_bad_length();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt;
        exp_ack_q.push_back(8'hE1);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h48); send_byte(8'h01);
        finish_ack("len");
        check_counts("len", d0, e0, t0, 0, 1, 0);
        total++;
        if (byte_cnt !== 16'd2) begin
            bad++;
            $display("FAIL len_cnt_hold got=%0d expected=2", byte_cnt);
        end
        test_good_frame();
    endtask

    task automatic test_resync();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt, a0;
        exp_tdata_q.push_back(8'h55);
        exp_ack_q.push_back(8'h1E);
        send_byte(8'h79); send_byte(8'h79); send_byte(8'h91); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h55); send_byte(8'h55);
        finish_ack("resync");
        check_counts("resync", d0, e0, t0, 1, 0, 1);
        a0 = ack_cnt;
        tx_ready = 1'b1;
        send_byte(8'h79);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL resync_busy got=%b expected=1", busy);
        end
        send_byte(8'h12);
        repeat (20) @(negedge clk_sys);
        tx_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || ack_cnt !== a0 || err_cnt !== e0) begin
            bad++;
            $display("FAIL resync_drop got busy=%b acks=%0d errs=%0d expected busy=0 acks=0 errs=0",
                     busy, ack_cnt - a0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_midframe();
        int d0 = done_cnt, e0 = err_cnt, a0 = ack_cnt;
        exp_tdata_q.push_back(8'h01); exp_tdata_q.push_back(8'h02);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        total++;
        if ({tdata, tvalid, byte_cnt, frame_done, frame_err, ack_data, ack_valid, busy} !== 37'd0) begin
            bad++;
            $display("FAIL midreset_outputs got tdata=%h cnt=%0d ack=%h busy=%b expected all 0",
                     tdata, byte_cnt, ack_data, busy);
        end
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (20) @(negedge clk_sys);
        tx_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || ack_cnt !== a0 || done_cnt !== d0 || err_cnt !== e0 || exp_tdata_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_quiet got busy=%b acks=%0d done=%0d err=%0d pend=%0d expected 0",
                     busy, ack_cnt - a0, done_cnt - d0, err_cnt - e0, exp_tdata_q.size());
        end
        test_good_frame();
    endtask

`ifdef UART_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt;
        exp_tdata_q.push_back(8'h0A);
        exp_ack_q.push_back(8'hE1);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h00); send_byte(8'h04); send_byte(8'h0A);
        for (int i = 0; i < TO_CYC + 50 && err_cnt == e0; i++) @(negedge clk_sys);
        total++;
        if (err_cnt !== e0 + 1) begin
            bad++;
            $display("FAIL timeout_err got=%0d expected=1", err_cnt - e0);
        end
        finish_ack("timeout");
        check_counts("timeout", d0, e0, t0, 0, 1, 1);
    endtask
`else
    task automatic test_timeout();
        int d0 = done_cnt, e0 = err_cnt, t0 = tv_cnt;
        exp_tdata_q.push_back(8'h33);
        exp_ack_q.push_back(8'h1E);
        send_byte(8'h79); send_byte(8'h91); send_byte(8'h00); send_byte(8'h01);
        repeat (TO_CYC + 100) @(negedge clk_sys);
        total++;
        if (busy !== 1'b1 || err_cnt !== e0) begin
            bad++;
            $display("FAIL no_timeout got busy=%b errs=%0d expected busy=1 errs=0", busy, err_cnt - e0);
        end
        send_byte(8'h33); send_byte(8'h33);
        finish_ack("no_timeout");
        check_counts("no_timeout", d0, e0, t0, 1, 0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_length();
        test_resync();
        test_reset_midframe();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
